// File: rtl/segasys1_iportx_if.sv
// CPU read port of the Sega System 1 input block.
// CPUCE/CPUIO/CPURD together form the sample point. DV/OD are registered one cycle later and hold until the next sample point.
interface segasys1_iportx_if;
  logic        CPUCE;
  logic [15:0] CPUAD;
  logic        CPUIO;
  logic        CPURD;
  logic        DV;
  logic [7:0]  OD;

  modport master (output CPUCE, CPUAD, CPUIO, CPURD, input DV, OD);
  modport slave  (input CPUCE, CPUAD, CPUIO, CPURD, output DV, OD);
endinterface

// File: rtl/segasys1_iportx.sv
// Debounced active-low input ports, DIP switch readback and coin pulse stretcher
// for the Sega System 1 CPU I/O space.
module segasys1_iportx #(
  parameter int          NPORT    = 3,
  parameter int          DBN      = 4,
  parameter int          PRESC    = 4800,
  parameter int          COINCH   = 2,
  parameter logic [7:0]  COINMASK = 8'h03,
  parameter int          COINHOLD = 3,
  parameter int          LEGACY   = 1
) (
  input  logic                 CLK48M,
  input  logic                 RESET,
  segasys1_iportx_if.slave     bus,
  input  logic                 VBLK,
  input  logic [8*NPORT-1:0]   INP,
  input  logic [7:0]           DSW0,
  input  logic [7:0]           DSW1
);
  localparam int         NB         = 8 * NPORT;
  localparam logic [3:0] DBN_LAST   = 4'(DBN - 1);
  localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);
  localparam logic [2:0] DSW_SEL    = 3'(NPORT);
  localparam bit         COIN_EN    = (COINCH < NPORT);
  localparam int         COIN_LSB   = COIN_EN ? 8 * COINCH : 0;
  localparam logic [3:0] HOLD_INIT  = 4'(COINHOLD);

  logic [15:0]          presc_q, presc_d;
  logic                 tick;
  logic [NB-1:0]        s1_q, s1_d, s2_q, s2_d, acc_q, acc_d;
  logic [NB-1:0][3:0]   cnt_q, cnt_d;
  logic [1:0]           vb_sync_q, vb_sync_d;
  logic                 vb_prev_q, vb_prev_d;
  logic                 vb_rise;
  logic [7:0][3:0]      hold_q, hold_d;
  logic [NB-1:0]        rd_val;
  logic [7:0]           od_q, od_d;
  logic                 dv_q, dv_d;
  logic                 bus_sp, sel;
  logic [7:0]           sel_data;
  logic [2:0]           chan;
  logic                 unused_ad;

  assign unused_ad = &{1'b0, bus.CPUAD[15:5]};

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // Counter only advances while the synchronised sample disagrees with the accepted value.
  always_comb begin
    s1_d  = INP;
    s2_d  = s1_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (tick) begin
      for (int i = 0; i < NB; i++) begin
        if (s2_q[i] == acc_q[i]) begin
          cnt_d[i] = 4'd0;
        end else if (cnt_q[i] == DBN_LAST) begin
          acc_d[i] = s2_q[i];
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    vb_sync_d = {vb_sync_q[0], VBLK};
    vb_prev_d = vb_sync_q[1];
    vb_rise   = vb_sync_q[1] & ~vb_prev_q;
  end

  // A fresh press reloads the hold and wins over a coincident frame decrement.
  always_comb begin
    hold_d = hold_q;
    rd_val = acc_q;
    for (int b = 0; b < 8; b++) begin
      if (COIN_EN && COINMASK[b]) begin
        if (acc_q[COIN_LSB+b] && !acc_d[COIN_LSB+b]) begin
          hold_d[b] = HOLD_INIT;
        end else if (vb_rise && hold_q[b] != 4'd0) begin
          hold_d[b] = hold_q[b] - 4'd1;
        end
        if (hold_q[b] != 4'd0) begin
          rd_val[COIN_LSB+b] = 1'b0;
        end
      end
    end
  end

  // The legacy DSW1 alias takes priority over a channel mapped to the same address.
  always_comb begin
    bus_sp   = bus.CPUCE & bus.CPUIO & bus.CPURD;
    chan     = bus.CPUAD[4:2];
    sel      = 1'b0;
    sel_data = 8'hFF;
    if (LEGACY != 0 && bus.CPUAD[4:0] == 5'h10) begin
      sel      = 1'b1;
      sel_data = DSW1;
    end else if (chan == DSW_SEL) begin
      sel      = 1'b1;
      sel_data = bus.CPUAD[0] ? DSW1 : DSW0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (chan == 3'(p)) begin
          sel      = 1'b1;
          sel_data = rd_val[8*p +: 8];
        end
      end
    end
    od_d = od_q;
    dv_d = dv_q;
    if (bus_sp) begin
      od_d = sel ? sel_data : 8'hFF;
      dv_d = sel;
    end
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      presc_q   <= '0;
      s1_q      <= '1;
      s2_q      <= '1;
      acc_q     <= '1;
      cnt_q     <= '0;
      vb_sync_q <= '0;
      vb_prev_q <= 1'b0;
      hold_q    <= '0;
      od_q      <= 8'hFF;
      dv_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      vb_sync_q <= vb_sync_d;
      vb_prev_q <= vb_prev_d;
      hold_q    <= hold_d;
      od_q      <= od_d;
      dv_q      <= dv_d;
    end
  end

  assign bus.DV = dv_q;
  assign bus.OD = od_q;
endmodule
